vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 121 ++++++++++++
 tb/tb_vga_sync_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator. A clock divider produces the pixel rate.
// Horizontal and vertical counters walk front porch, sync, back porch and
// then the visible region. All decoded outputs are registered and are
// computed from the counters' next values, so they line up with
// h_count/v_count in the same cycle and have no decode glitches.
module vga_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 29,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       bright,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
  localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE;

  localparam logic [9:0] H_MAX     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_LO = 10'(H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_FP + H_SYNC);        // first h after sync
  localparam logic [9:0] H_VIS_LO  = 10'(H_FP + H_SYNC + H_BP);
  localparam logic [9:0] V_MAX     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_LO = 10'(V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_FP + V_SYNC);        // first line after sync
  localparam logic [9:0] V_VIS_LO  = 10'(V_FP + V_SYNC + V_BP);
  localparam logic [3:0] DIV_MAX   = 4'(CLK_DIV - 1);

  logic [3:0] r_div;
  logic       r_tick;
  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_bright;
  logic       r_frame;

  logic [3:0] w_div_next;
  logic       w_h_last;
  logic       w_v_last;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_hsync_next;
  logic       w_vsync_next;
  logic       w_bright_next;

  // Next-state values for the divider and counters, and the decode of those next values
  always_comb begin
    w_div_next    = (r_div == DIV_MAX) ? 4'd0 : r_div + 4'd1;
    w_h_last      = (r_h == H_MAX);
    w_v_last      = (r_v == V_MAX);
    w_h_next      = r_h;
    w_v_next      = r_v;
    if (r_tick) begin
      w_h_next = w_h_last ? 10'd0 : r_h + 10'd1;
      if (w_h_last)
        w_v_next = w_v_last ? 10'd0 : r_v + 10'd1;
    end
    w_hsync_next  = !((w_h_next >= H_SYNC_LO) && (w_h_next < H_SYNC_HI));
    w_vsync_next  = !((w_v_next >= V_SYNC_LO) && (w_v_next < V_SYNC_HI));
    w_bright_next = (w_h_next >= H_VIS_LO) && (w_v_next >= V_VIS_LO);
  end

  // Pixel-rate divider; the tick is high while the divider sits at its last count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div  <= 4'd0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= w_div_next;
      r_tick <= (w_div_next == DIV_MAX);
    end
  end

  // Raster position counters, advanced once per pixel tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h <= 10'd0;
      r_v <= 10'd0;
    end else begin
      r_h <= w_h_next;
      r_v <= w_v_next;
    end
  end

  // Registered sync/blanking decode and the one-cycle frame marker after the last pixel wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
      r_bright <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_hsync  <= w_hsync_next;
      r_vsync  <= w_vsync_next;
      r_bright <= w_bright_next;
      r_frame  <= r_tick && w_h_last && w_v_last;
    end
  end

  assign h_count     = r_h;
  assign v_count     = r_v;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign bright      = r_bright;
  assign pixel_tick  = r_tick;
  assign frame_start = r_frame;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. Three instances: A uses the default 640x480 timing,
// B a tiny 38x17 raster (divide by 2) so whole frames fit in a short run,
// C the default geometry at one clock per pixel. Cycle index k counts
// rising edges after the common reset release; expected values are
// hand-derived from pixel = floor(k / CLK_DIV).
module tb_vga_sync_gen;

  localparam int K_H = 0, K_V = 1, K_HS = 2, K_VS = 3, K_BR = 4, K_TICK = 5,
                 K_FS = 6, K_BRCNT = 7, K_VIOL = 8, K_FSCNT = 9;
  localparam int A = 0, B = 1, C = 2;

  typedef struct {
    int d;
    int k;
    int kind;
    int e;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, rst_c;
  logic [9:0] hc [3];
  logic [9:0] vc [3];
  logic       hs [3];
  logic       vs [3];
  logic       br [3];
  logic       pt [3];
  logic       fs [3];

  item_t sbq [$];
  int    edges = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  int    br_cnt [3] = '{0, 0, 0};
  int    viol_cnt [3] = '{0, 0, 0};
  int    fs_cnt [3] = '{0, 0, 0};
  string dname [3] = '{"A", "B", "C"};
  string kname [10] = '{"h_count", "v_count", "hsync", "vsync", "bright",
                        "pixel_tick", "frame_start", "bright_ticks",
                        "bright_in_sync", "frame_pulses"};

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  vga_sync_gen u_a (
    .clk(clk), .reset(rst_a), .h_count(hc[0]), .v_count(vc[0]), .hsync(hs[0]),
    .vsync(vs[0]), .bright(br[0]), .pixel_tick(pt[0]), .frame_start(fs[0])
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_FP(4), .H_SYNC(8), .H_BP(6), .H_ACTIVE(20),
    .V_FP(2), .V_SYNC(2), .V_BP(3), .V_ACTIVE(10)
  ) u_b (
    .clk(clk), .reset(rst_b), .h_count(hc[1]), .v_count(vc[1]), .hsync(hs[1]),
    .vsync(vs[1]), .bright(br[1]), .pixel_tick(pt[1]), .frame_start(fs[1])
  );

  vga_sync_gen #(.CLK_DIV(1)) u_c (
    .clk(clk), .reset(rst_c), .h_count(hc[2]), .v_count(vc[2]), .hsync(hs[2]),
    .vsync(vs[2]), .bright(br[2]), .pixel_tick(pt[2]), .frame_start(fs[2])
  );

  task automatic push(input int d, input int k, input int kind, input int e);
    item_t it;
    it.d = d; it.k = k; it.kind = kind; it.e = e;
    sbq.push_back(it);
  endtask

  task automatic push_hv(input int d, input int k, input int h, input int v);
    push(d, k, K_H, h);
    push(d, k, K_V, v);
  endtask

  task automatic push_reset_state(input int d, input int k);
    push_hv(d, k, 0, 0);
    push(d, k, K_TICK, 0);
    push(d, k, K_HS, 1);
    push(d, k, K_VS, 1);
    push(d, k, K_BR, 0);
    push(d, k, K_FS, 0);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  function automatic int sample(input int d, input int kind);
    case (kind)
      K_H:     return int'(hc[d]);
      K_V:     return int'(vc[d]);
      K_HS:    return int'(hs[d]);
      K_VS:    return int'(vs[d]);
      K_BR:    return int'(br[d]);
      K_TICK:  return int'(pt[d]);
      K_FS:    return int'(fs[d]);
      K_BRCNT: return br_cnt[d];
      K_VIOL:  return viol_cnt[d];
      K_FSCNT: return fs_cnt[d];
      default: return -1;
    endcase
  endfunction

  // Monitor: on every falling edge, pop and compare all expectations due this cycle
  initial begin
    int mon_k;
    int idx;
    forever begin
      @(negedge clk);
      mon_k = edges - 3;
      idx = 0;
      while (idx < sbq.size()) begin
        if (sbq[idx].k == mon_k) begin
          check($sformatf("%s.%s@k%0d", dname[sbq[idx].d], kname[sbq[idx].kind], mon_k),
                sample(sbq[idx].d, sbq[idx].kind), sbq[idx].e);
          sbq.delete(idx);
        end else begin
          idx++;
        end
      end
      for (int d = 0; d < 3; d++) begin
        if (pt[d] && br[d]) br_cnt[d]++;
        if (br[d] && (!hs[d] || !vs[d])) viol_cnt[d]++;
        if (fs[d]) fs_cnt[d]++;
      end
    end
  end

  // Driver: resets, reset-release expectations, mid-frame reset on B
  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    for (int d = 0; d < 3; d++) push_reset_state(d, -1);

    repeat (3) @(posedge clk);
    #2;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // A: default timing, two clocks per pixel
    push_reset_state(A, 0);
    push(A, 1, K_TICK, 1);    push(A, 1, K_H, 0);
    push(A, 2, K_TICK, 0);    push(A, 2, K_H, 1);
    push(A, 31, K_H, 15);     push(A, 31, K_HS, 1);
    push(A, 32, K_H, 16);     push(A, 32, K_HS, 0);
    push(A, 222, K_H, 111);   push(A, 222, K_HS, 0);
    push(A, 224, K_H, 112);   push(A, 224, K_HS, 1);
    push(A, 318, K_H, 159);   push(A, 318, K_BR, 0);
    push(A, 320, K_H, 160);   push(A, 320, K_BR, 0);
    push_hv(A, 1598, 799, 0);
    push_hv(A, 1600, 0, 1);
    push(A, 15999, K_V, 9);   push(A, 15999, K_VS, 1);
    push(A, 16000, K_V, 10);  push(A, 16000, K_VS, 0);
    push(A, 19199, K_V, 11);  push(A, 19199, K_VS, 0);
    push(A, 19200, K_V, 12);  push(A, 19200, K_VS, 1);
    push_hv(A, 65598, 799, 40);
    push_hv(A, 65600, 0, 41); push(A, 65600, K_BR, 0);
    push(A, 65919, K_H, 159); push(A, 65919, K_BR, 0);
    push_hv(A, 65920, 160, 41); push(A, 65920, K_BR, 1);
    push(A, 65990, K_VIOL, 0);
    push(A, 65990, K_FSCNT, 0);

    // C: default geometry, one clock per pixel
    push(C, 0, K_TICK, 0);    push(C, 0, K_H, 0);
    push(C, 1, K_TICK, 1);    push(C, 1, K_H, 0);
    push(C, 2, K_TICK, 1);    push(C, 2, K_H, 1);
    push(C, 100, K_TICK, 1);  push(C, 100, K_H, 99);
    push(C, 16, K_H, 15);     push(C, 16, K_HS, 1);
    push(C, 17, K_H, 16);     push(C, 17, K_HS, 0);
    push_hv(C, 800, 799, 0);
    push_hv(C, 801, 0, 1);
    push_hv(C, 1601, 0, 2);
    push(C, 32960, K_H, 159); push(C, 32960, K_BR, 0);
    push_hv(C, 32961, 160, 41); push(C, 32961, K_BR, 1);

    // B: 38x17 raster, sync h 4..11 / v 2..3, visible h 18..37 / v 7..16
    push(B, 7, K_H, 3);       push(B, 7, K_HS, 1);
    push(B, 8, K_H, 4);       push(B, 8, K_HS, 0);
    push(B, 22, K_H, 11);     push(B, 22, K_HS, 0);
    push(B, 24, K_H, 12);     push(B, 24, K_HS, 1);
    push_hv(B, 151, 37, 1);   push(B, 151, K_VS, 1);
    push_hv(B, 152, 0, 2);    push(B, 152, K_VS, 0);
    push(B, 303, K_VS, 0);
    push_hv(B, 304, 0, 4);    push(B, 304, K_VS, 1);
    push_hv(B, 567, 17, 7);   push(B, 567, K_BR, 0);
    push_hv(B, 568, 18, 7);   push(B, 568, K_BR, 1);
    push_hv(B, 1291, 37, 16); push(B, 1291, K_BR, 1); push(B, 1291, K_FS, 0);
    push_hv(B, 1292, 0, 0);   push(B, 1292, K_FS, 1); push(B, 1292, K_BR, 0);
    push(B, 1293, K_FS, 0);
    push(B, 1292, K_BRCNT, 200);
    push(B, 2584, K_BRCNT, 400);
    push(B, 2584, K_FS, 1);
    push(B, 3876, K_BRCNT, 600);
    push(B, 3876, K_FS, 1);
    push(B, 3876, K_VIOL, 0);
    push(B, 3877, K_FSCNT, 3);
    push_hv(B, 4610, 25, 9);  push(B, 4610, K_BR, 1);
    push(B, 4610, K_HS, 1);   push(B, 4610, K_VS, 1);

    // Mid-frame asynchronous reset on B, between clock edges
    repeat (4611) @(posedge clk);
    #2;
    rst_b = 1'b1;
    push_reset_state(B, 4611);

    repeat (9) @(posedge clk);
    #2;
    rst_b = 1'b0;
    push(B, 4620, K_TICK, 0); push_hv(B, 4620, 0, 0);
    push(B, 4621, K_TICK, 1); push_hv(B, 4621, 0, 0);
    push(B, 4622, K_TICK, 0); push_hv(B, 4622, 1, 0);
    push_hv(B, 4696, 0, 1);
    push(B, 5912, K_FSCNT, 3);
    push_hv(B, 5912, 0, 0);   push(B, 5912, K_FS, 1);
    push(B, 5913, K_FS, 0);
    push(B, 5914, K_FSCNT, 4);

    repeat (66000 - 4620) @(posedge clk);
    @(negedge clk);
    #1;
    foreach (sbq[i]) begin
      n_checks++;
      $display("FAIL %s.%s@k%0d: never sampled, want %0d",
               dname[sbq[i].d], kname[sbq[i].kind], sbq[i].k, sbq[i].e);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
